ahb_slave_if_param: RTL and testbench

- Parametrised AHB-Lite slave front end for the AHB-to-APB bridge.
- Decodes haddr into NUM_SLAVES equal APB regions and qualifies transfers.
- Pipelines address, data and control for the APB FSM; drives hready_out and hresp.
- Adds over the fixed 3-slave version: generic width and slave count, stall-aware capture, downstream back-pressure and a two-cycle AHB ERROR response.

---
 rtl/ahb_slave_if_param_pkg.sv | 24 ++
 rtl/ahb_slave_if_param_if.sv | 44 ++++
 rtl/ahb_slave_if_param_decode.sv | 30 +++
 rtl/ahb_slave_if_param.sv | 101 ++++++++++
 tb/tb_ahb_slave_if_param.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/ahb_slave_if_param_pkg.sv
// Shared AHB constants, error FSM state type and select-width helper for the
// AHB-to-APB bridge front end.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } err_state_e;

    // One-hot select width; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/ahb_slave_if_param_if.sv
// AHB-Lite slave side bundle plus the pipelined outputs handed to the APB FSM.
interface ahb_slave_if_param_if
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 3
) ();
    localparam int SEL_W = sel_w(NUM_SLAVES);

    logic              hready_in;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] prdata;
    logic              bridge_ready;

    logic              valid;
    logic [SEL_W-1:0]  selx;
    logic              hwritereg;
    logic              hwritereg_1;
    logic [ADDR_W-1:0] haddr_1;
    logic [ADDR_W-1:0] haddr_2;
    logic [DATA_W-1:0] hwdata_1;
    logic [DATA_W-1:0] hwdata_2;
    logic              hready_out;
    logic [1:0]        hresp;
    logic [DATA_W-1:0] hrdata;

    modport slave (
        input  hready_in, htrans, hwrite, hsize, haddr, hwdata, prdata, bridge_ready,
        output valid, selx, hwritereg, hwritereg_1, haddr_1, haddr_2,
               hwdata_1, hwdata_2, hready_out, hresp, hrdata
    );

    modport master (
        output hready_in, htrans, hwrite, hsize, haddr, hwdata, prdata, bridge_ready,
        input  valid, selx, hwritereg, hwritereg_1, haddr_1, haddr_2,
               hwdata_1, hwdata_2, hready_out, hresp, hrdata
    );

endinterface

// File: rtl/ahb_slave_if_param_decode.sv
// Combinational region decode: equal 2^REGION_LOG2 regions from BASE_ADDR,
// plus a transfer-size legality check against the data width.
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_SLAVES  = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h8000_0000),
    parameter int                REGION_LOG2 = 26
) (
    input  logic [ADDR_W-1:0]              haddr,
    input  logic [2:0]                     hsize,
    output logic                           mapped,
    output logic                           size_ok,
    output logic [sel_w(NUM_SLAVES)-1:0]   onehot
);
    logic [ADDR_W-1:0] offs;
    logic [ADDR_W-1:0] idx;

    assign offs    = haddr - BASE_ADDR;
    assign idx     = offs >> REGION_LOG2;
    assign mapped  = (haddr >= BASE_ADDR) && (idx < ADDR_W'(NUM_SLAVES));
    assign size_ok = (32'd8 << hsize) <= 32'(DATA_W);

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_sel
        assign onehot[i] = mapped && (idx == ADDR_W'(i));
    end

endmodule

// File: rtl/ahb_slave_if_param.sv
// AHB-Lite slave front end for the AHB-to-APB bridge. Define AHB_SLV_ERR_RESP_EN
// to enable the two-cycle ERROR response; otherwise bad transfers are dropped.
module ahb_slave_if_param
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_SLAVES  = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h8000_0000),
    parameter int                REGION_LOG2 = 26
) (
    input  logic               hclk,
    input  logic               hreset,
    ahb_slave_if_param_if.slave bus
);
    localparam int SEL_W = sel_w(NUM_SLAVES);

    logic             active;
    logic             mapped;
    logic             size_ok;
    logic             cap;
    logic [SEL_W-1:0] onehot;

    ahb_addr_decode #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_SLAVES  (NUM_SLAVES),
        .BASE_ADDR   (BASE_ADDR),
        .REGION_LOG2 (REGION_LOG2)
    ) u_dec (
        .haddr   (bus.haddr),
        .hsize   (bus.hsize),
        .mapped  (mapped),
        .size_ok (size_ok),
        .onehot  (onehot)
    );

    assign active     = bus.hready_in &&
                        (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ);
    assign bus.valid  = active && mapped && size_ok;
    assign cap        = bus.hready_in && bus.hready_out;
    assign bus.hrdata = bus.prdata;

    // hwdata arrives one phase late, so it shifts on the same accept as the address.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            bus.haddr_1     <= '0;
            bus.haddr_2     <= '0;
            bus.hwritereg   <= 1'b0;
            bus.hwritereg_1 <= 1'b0;
            bus.hwdata_1    <= '0;
            bus.hwdata_2    <= '0;
            bus.selx        <= '0;
        end else if (cap) begin
            bus.haddr_1     <= bus.haddr;
            bus.haddr_2     <= bus.haddr_1;
            bus.hwritereg   <= bus.hwrite;
            bus.hwritereg_1 <= bus.hwritereg;
            bus.hwdata_1    <= bus.hwdata;
            bus.hwdata_2    <= bus.hwdata_1;
            bus.selx        <= bus.valid ? onehot : '0;
        end
    end

`ifdef AHB_SLV_ERR_RESP_EN
    err_state_e state, state_nxt;
    logic       bad;

    assign bad = active && !(mapped && size_ok);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Accept in IDLE is hready_in & bridge_ready; in ERR2 hready_out is forced high.
    always_comb begin
        state_nxt      = state;
        bus.hready_out = bus.bridge_ready;
        bus.hresp      = HRESP_OKAY;
        case (state)
            ST_IDLE: if (bus.bridge_ready && bad) state_nxt = ST_ERR1;
            ST_ERR1: begin
                bus.hready_out = 1'b0;
                bus.hresp      = HRESP_ERROR;
                state_nxt      = ST_ERR2;
            end
            ST_ERR2: begin
                bus.hready_out = 1'b1;
                bus.hresp      = HRESP_ERROR;
                state_nxt      = bad ? ST_ERR1 : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
`else
    assign bus.hready_out = bus.bridge_ready;
    assign bus.hresp      = HRESP_OKAY;
`endif

endmodule

// File: tb/tb_ahb_slave_if_param.sv
// Scoreboard bench for ahb_slave_if_param; expectations follow AHB_SLV_ERR_RESP_EN.
module tb_ahb_slave_if_param;
    import ahb_apb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;
`ifdef AHB_SLV_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [NS-1:0] sel;
        logic [DW-1:0] wdata;
        logic          wr;
    } exp_t;

    logic hclk = 1'b0;
    logic hreset = 1'b0;
    int   checks = 0;
    int   passed = 0;
    exp_t exp_q[$];

    ahb_slave_if_param_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS)) bus ();

    ahb_slave_if_param #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    always #5 hclk = ~hclk;

    task automatic drive(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
        bus.htrans = tr;
        bus.hwrite = wr;
        bus.hsize  = sz;
        bus.haddr  = a;
        bus.hwdata = wd;
    endtask

    task automatic step();
        @(posedge hclk);
        @(negedge hclk);
    endtask

    task automatic test_reset();
        bus.hready_in    = 1'b1;
        bus.bridge_ready = 1'b1;
        bus.prdata       = '0;
        drive(HTRANS_IDLE, 1'b0, 3'd2, '0, '0);
        #3 hreset = 1'b1;
        #1;
        checks++; if ({bus.haddr_1, bus.haddr_2} !== 64'h0) $display("FAIL reset_addr got %h %h want 0", bus.haddr_1, bus.haddr_2); else passed++;
        checks++; if ({bus.hwdata_1, bus.hwdata_2} !== 64'h0) $display("FAIL reset_wdata got %h %h want 0", bus.hwdata_1, bus.hwdata_2); else passed++;
        checks++; if ({bus.selx, bus.hwritereg, bus.hwritereg_1} !== 5'b0) $display("FAIL reset_sel got %b %b %b want 0", bus.selx, bus.hwritereg, bus.hwritereg_1); else passed++;
        checks++; if ({bus.hready_out, bus.hresp} !== 3'b100) $display("FAIL reset_resp got %b %b want 1 00", bus.hready_out, bus.hresp); else passed++;
        @(negedge hclk);
        hreset = 1'b0;
    endtask

    task automatic test_decode();
        logic [AW-1:0] addrs [3];
        logic [NS-1:0] sels  [3];
        exp_t          e;
        exp_t          prev;
        addrs = '{32'h8000_0010, 32'h8400_0000, 32'h8BFF_FFFC};
        sels  = '{3'b001, 3'b010, 3'b100};
        for (int k = 0; k < 3; k++) begin
            drive(HTRANS_NONSEQ, 1'b1, 3'd2, addrs[k], 32'hD000_0000 + k);
            #1;
            checks++; if (bus.valid !== 1'b1) $display("FAIL decode_valid[%0d] got %b want 1", k, bus.valid); else passed++;
            exp_q.push_back('{addrs[k], sels[k], 32'hD000_0000 + k, 1'b1});
            step();
            e = exp_q.pop_front();
            checks++; if (bus.selx !== e.sel) $display("FAIL decode_selx[%0d] got %b want %b", k, bus.selx, e.sel); else passed++;
            checks++; if (bus.haddr_1 !== e.addr) $display("FAIL decode_haddr1[%0d] got %h want %h", k, bus.haddr_1, e.addr); else passed++;
            checks++; if ({bus.hwdata_1, bus.hwritereg} !== {e.wdata, e.wr}) $display("FAIL decode_wdata1[%0d] got %h/%b want %h/%b", k, bus.hwdata_1, bus.hwritereg, e.wdata, e.wr); else passed++;
            if (k > 0) begin
                checks++; if (bus.haddr_2 !== prev.addr) $display("FAIL decode_haddr2[%0d] got %h want %h", k, bus.haddr_2, prev.addr); else passed++;
            end
            prev = e;
        end
        drive(HTRANS_IDLE, 1'b0, 3'd2, '0, '0);
        #1;
        checks++; if (bus.valid !== 1'b0) $display("FAIL decode_idle_valid got %b want 0", bus.valid); else passed++;
        step();
        checks++; if (bus.haddr_2 !== prev.addr) $display("FAIL decode_haddr2_last got %h want %h", bus.haddr_2, prev.addr); else passed++;
        checks++; if (bus.selx !== 3'b000) $display("FAIL decode_idle_selx got %b want 000", bus.selx); else passed++;
    endtask

    task automatic test_hrdata();
        logic [DW-1:0] v;
        for (int k = 0; k < 2; k++) begin
            v = $urandom;
            bus.prdata = v;
            #1;
            checks++; if (bus.hrdata !== v) $display("FAIL hrdata[%0d] got %h want %h", k, bus.hrdata, v); else passed++;
        end
    endtask

    task automatic test_error(input string nm, input logic [AW-1:0] a, input logic [2:0] sz);
        logic [2:0] exp1, exp2;
        exp1 = ERR_EN ? 3'b001 : 3'b100;
        exp2 = ERR_EN ? 3'b101 : 3'b100;
        drive(HTRANS_NONSEQ, 1'b0, sz, a, '0);
        #1;
        checks++; if (bus.valid !== 1'b0) $display("FAIL %s_valid got %b want 0", nm, bus.valid); else passed++;
        step();
        drive(HTRANS_IDLE, 1'b0, 3'd2, '0, '0);
        #1;
        checks++; if ({bus.hready_out, bus.hresp} !== exp1) $display("FAIL %s_cyc1 got %b want %b", nm, {bus.hready_out, bus.hresp}, exp1); else passed++;
        checks++; if (bus.selx !== 3'b000) $display("FAIL %s_selx got %b want 000", nm, bus.selx); else passed++;
        step();
        checks++; if ({bus.hready_out, bus.hresp} !== exp2) $display("FAIL %s_cyc2 got %b want %b", nm, {bus.hready_out, bus.hresp}, exp2); else passed++;
        step();
        checks++; if ({bus.hready_out, bus.hresp, bus.selx} !== 6'b100_000) $display("FAIL %s_done got %b %b %b want 1 00 000", nm, bus.hready_out, bus.hresp, bus.selx); else passed++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        drive(HTRANS_NONSEQ, 1'b1, 3'd2, 32'h8000_0000, 32'h11);
        exp_q.push_back('{32'h8000_0000, 3'b001, 32'h11, 1'b1});
        step();
        e = exp_q.pop_front();
        checks++; if (bus.haddr_1 !== e.addr) $display("FAIL bp_first got %h want %h", bus.haddr_1, e.addr); else passed++;
        drive(HTRANS_SEQ, 1'b1, 3'd2, 32'h8000_0004, 32'hA0);
        bus.bridge_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.hready_out !== 1'b0) $display("FAIL bp_stall[%0d] got %b want 0", k, bus.hready_out); else passed++;
            step();
            checks++; if ({bus.haddr_1, bus.hwdata_1} !== {e.addr, e.wdata}) $display("FAIL bp_hold[%0d] got %h/%h want %h/%h", k, bus.haddr_1, bus.hwdata_1, e.addr, e.wdata); else passed++;
        end
        bus.bridge_ready = 1'b1;
        #1;
        checks++; if (bus.hready_out !== 1'b1) $display("FAIL bp_release got %b want 1", bus.hready_out); else passed++;
        exp_q.push_back('{32'h8000_0004, 3'b001, 32'hA0, 1'b1});
        step();
        drive(HTRANS_SEQ, 1'b1, 3'd2, 32'h8000_0008, 32'hA1);
        exp_q.push_back('{32'h8000_0008, 3'b001, 32'hA1, 1'b1});
        e = exp_q.pop_front();
        checks++; if ({bus.haddr_1, bus.hwdata_1, bus.haddr_2} !== {e.addr, e.wdata, 32'h8000_0000}) $display("FAIL bp_beat1 got %h/%h/%h want %h/%h/80000000", bus.haddr_1, bus.hwdata_1, bus.haddr_2, e.addr, e.wdata); else passed++;
        step();
        drive(HTRANS_IDLE, 1'b0, 3'd2, '0, '0);
        e = exp_q.pop_front();
        checks++; if ({bus.haddr_1, bus.hwdata_1, bus.haddr_2} !== {e.addr, e.wdata, 32'h8000_0004}) $display("FAIL bp_beat2 got %h/%h/%h want %h/%h/80000004", bus.haddr_1, bus.hwdata_1, bus.haddr_2, e.addr, e.wdata); else passed++;
        checks++; if (exp_q.size() !== 0) $display("FAIL bp_queue got %0d left want 0", exp_q.size()); else passed++;
        step();
    endtask

    task automatic test_reset_mid_error();
        drive(HTRANS_NONSEQ, 1'b0, 3'd2, 32'h9000_0000, '0);
        step();
        drive(HTRANS_IDLE, 1'b0, 3'd2, '0, '0);
        #1;
        checks++; if (bus.hready_out !== !ERR_EN) $display("FAIL rst_err_pre got %b want %b", bus.hready_out, !ERR_EN); else passed++;
        #2 hreset = 1'b1;
        #1;
        checks++; if ({bus.hready_out, bus.hresp} !== 3'b100) $display("FAIL rst_err_resp got %b %b want 1 00", bus.hready_out, bus.hresp); else passed++;
        checks++; if ({bus.selx, bus.haddr_1} !== 35'h0) $display("FAIL rst_err_regs got %b %h want 0", bus.selx, bus.haddr_1); else passed++;
        @(negedge hclk);
        hreset = 1'b0;
        drive(HTRANS_NONSEQ, 1'b1, 3'd2, 32'h8400_0004, 32'h5);
        #1;
        checks++; if (bus.valid !== 1'b1) $display("FAIL rst_err_valid got %b want 1", bus.valid); else passed++;
        step();
        checks++; if ({bus.selx, bus.haddr_1} !== {3'b010, 32'h8400_0004}) $display("FAIL rst_err_after got %b %h want 010 84000004", bus.selx, bus.haddr_1); else passed++;
        drive(HTRANS_IDLE, 1'b0, 3'd2, '0, '0);
        step();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_hrdata();
        test_error("unmapped", 32'h8C00_0000, 3'd2);
        test_error("oversize", 32'h8000_0000, 3'd3);
        test_backpressure();
        test_reset_mid_error();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
